// File: rtl/ds_timming_flow_parser.sv
// Timing-flow frame parser: beat-0 header fields are latched, payload beats go to the FIFO; all outputs are registered one cycle behind the input beat.
// No backpressure: payload beats that meet a full FIFO are dropped and flagged. Define DS_FRAME_CNT_CHECK_EN to check that header frame_cnt values arrive in sequence.
module ds_timming_flow_parser #(
  parameter logic [31:0] HEADER_WORD    = 32'hFDF7_EB90,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic         sys_clk_i,
  input  logic         rst_i,
  input  logic         us_timming_flow_vld_i,
  input  logic [127:0] us_timming_flow_i,
  output logic         ds_timming_wr_en_o,
  output logic [127:0] ds_timming_din_o,
  input  logic         ds_timming_full_i,
  output logic         frame_done_pluse_o,
  output logic         frame_err_o,
  output logic [7:0]   src_id_o,
  output logic [7:0]   data_type_o,
  output logic [7:0]   data_channel_o,
  output logic [15:0]  frame_cnt_o,
  output logic         err_header_pluse_o,
  output logic         err_timeout_pluse_o,
  output logic         err_overflow_pluse_o,
  output logic         err_seq_pluse_o,
  output logic [15:0]  rx_frame_total_o
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_t;

  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [12:0]   beat_cnt_q, beat_cnt_d;
  logic [12:0]   beat_num_q, beat_num_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
  logic          err_flag_q, err_flag_d;
  logic          wr_en_q, wr_en_d;
  logic [127:0]  din_q, din_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    type_q, type_d;
  logic [7:0]    chan_q, chan_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          err_hdr_q, err_hdr_d;
  logic          err_to_q, err_to_d;
  logic          err_ov_q, err_ov_d;
  logic [15:0]   total_q, total_d;

  logic          hdr_match;
  logic [12:0]   n_beats;
  logic          last_beat;
  logic          seq_bad;

`ifdef DS_FRAME_CNT_CHECK_EN
  logic [15:0]   prev_cnt_q, prev_cnt_d;
  logic          seen_q, seen_d;
  logic          err_seq_q, err_seq_d;

  // First header after reset has no predecessor, so it is always in sequence.
  assign seq_bad = seen_q && (us_timming_flow_i[75:60] != 16'(prev_cnt_q + 16'd1));
`else
  assign seq_bad = 1'b0;
`endif

  assign hdr_match = (us_timming_flow_i[127:96] == HEADER_WORD);
  assign n_beats   = 13'(({1'b0, us_timming_flow_i[27:12]} + 17'd15) >> 4);
  assign last_beat = (beat_cnt_q == 13'(beat_num_q - 13'd1));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    beat_num_d = beat_num_q;
    gap_cnt_d  = gap_cnt_q;
    err_flag_d = err_flag_q;
    din_d      = din_q;
    src_d      = src_q;
    type_d     = type_q;
    chan_d     = chan_q;
    fcnt_d     = fcnt_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    err_hdr_d  = 1'b0;
    err_to_d   = 1'b0;
    err_ov_d   = 1'b0;
    total_d    = (done_q && !ferr_q) ? 16'(total_q + 16'd1) : total_q;
`ifdef DS_FRAME_CNT_CHECK_EN
    prev_cnt_d = prev_cnt_q;
    seen_d     = seen_q;
    err_seq_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (us_timming_flow_vld_i) begin
          if (hdr_match) begin
            fcnt_d     = us_timming_flow_i[75:60];
            src_d      = us_timming_flow_i[59:52];
            type_d     = us_timming_flow_i[43:36];
            chan_d     = us_timming_flow_i[35:28];
            beat_num_d = n_beats;
            beat_cnt_d = '0;
            gap_cnt_d  = '0;
            err_flag_d = seq_bad;
`ifdef DS_FRAME_CNT_CHECK_EN
            err_seq_d  = seq_bad;
            prev_cnt_d = us_timming_flow_i[75:60];
            seen_d     = 1'b1;
`endif
            if (n_beats == 13'd0) begin
              done_d = 1'b1;
              ferr_d = seq_bad;
            end else begin
              state_d = S_PAYLOAD;
            end
          end else begin
            err_hdr_d = 1'b1;
          end
        end
      end

      S_PAYLOAD: begin
        if (us_timming_flow_vld_i) begin
          // A beat landing on the timeout cycle still counts as payload.
          gap_cnt_d  = '0;
          din_d      = us_timming_flow_i;
          wr_en_d    = !ds_timming_full_i;
          err_ov_d   = ds_timming_full_i;
          err_flag_d = err_flag_q | ds_timming_full_i;
          if (last_beat) begin
            done_d  = 1'b1;
            ferr_d  = err_flag_q | ds_timming_full_i;
            state_d = S_IDLE;
          end else begin
            beat_cnt_d = 13'(beat_cnt_q + 13'd1);
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_DRAIN;
        end else begin
          gap_cnt_d = 16'(gap_cnt_q + 16'd1);
        end
      end

      S_DRAIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      beat_num_q <= '0;
      gap_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      src_q      <= '0;
      type_q     <= '0;
      chan_q     <= '0;
      fcnt_q     <= '0;
      err_hdr_q  <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      total_q    <= '0;
`ifdef DS_FRAME_CNT_CHECK_EN
      prev_cnt_q <= '0;
      seen_q     <= 1'b0;
      err_seq_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      beat_num_q <= beat_num_d;
      gap_cnt_q  <= gap_cnt_d;
      err_flag_q <= err_flag_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      src_q      <= src_d;
      type_q     <= type_d;
      chan_q     <= chan_d;
      fcnt_q     <= fcnt_d;
      err_hdr_q  <= err_hdr_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
      total_q    <= total_d;
`ifdef DS_FRAME_CNT_CHECK_EN
      prev_cnt_q <= prev_cnt_d;
      seen_q     <= seen_d;
      err_seq_q  <= err_seq_d;
`endif
    end
  end

  assign ds_timming_wr_en_o   = wr_en_q;
  assign ds_timming_din_o     = din_q;
  assign frame_done_pluse_o   = done_q;
  assign frame_err_o          = ferr_q;
  assign src_id_o             = src_q;
  assign data_type_o          = type_q;
  assign data_channel_o       = chan_q;
  assign frame_cnt_o          = fcnt_q;
  assign err_header_pluse_o   = err_hdr_q;
  assign err_timeout_pluse_o  = err_to_q;
  assign err_overflow_pluse_o = err_ov_q;
  assign rx_frame_total_o     = total_q;
`ifdef DS_FRAME_CNT_CHECK_EN
  assign err_seq_pluse_o      = err_seq_q;
`else
  assign err_seq_pluse_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ds_timming_flow_parser.sv
// Randomized bench for ds_timming_flow_parser: a per-cycle stimulus list is turned into expected
// output events by a frame-level reference walk, then replayed against the DUT cycle by cycle.
module tb_ds_timming_flow_parser;
  localparam logic [31:0] HDR = 32'hFDF7_EB90;
  localparam int          TMO = 8;

  logic         sys_clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         vld_i = 1'b0;
  logic [127:0] flow_i = '0;
  logic         full_i = 1'b0;
  logic         wr_en_o, done_o, ferr_o, eh_o, eto_o, eov_o, eseq_o;
  logic [127:0] din_o;
  logic [7:0]   src_o, type_o, chan_o;
  logic [15:0]  fcnt_o, total_o;

  ds_timming_flow_parser #(.HEADER_WORD(HDR), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk_i            (sys_clk_i),
    .rst_i                (rst_i),
    .us_timming_flow_vld_i(vld_i),
    .us_timming_flow_i    (flow_i),
    .ds_timming_wr_en_o   (wr_en_o),
    .ds_timming_din_o     (din_o),
    .ds_timming_full_i    (full_i),
    .frame_done_pluse_o   (done_o),
    .frame_err_o          (ferr_o),
    .src_id_o             (src_o),
    .data_type_o          (type_o),
    .data_channel_o       (chan_o),
    .frame_cnt_o          (fcnt_o),
    .err_header_pluse_o   (eh_o),
    .err_timeout_pluse_o  (eto_o),
    .err_overflow_pluse_o (eov_o),
    .err_seq_pluse_o      (eseq_o),
    .rx_frame_total_o     (total_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  bit           q_vld[$];
  bit           q_full[$];
  bit           q_rst[$];
  logic [127:0] q_dat[$];

  bit           e_wr[], e_done[], e_ferr[], e_eh[], e_to[], e_ov[], e_seq[], fld_set[];
  logic [127:0] e_din[];
  logic [39:0]  fld_val[], e_fld[];
  logic [15:0]  e_total[];

  int           n_chk = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [15:0]  seq_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [31:0] h, input logic [15:0] len,
                                          input logic [15:0] cnt, input logic [7:0] src,
                                          input logic [7:0] typ, input logic [7:0] chan);
    logic [31:0] r;
    r = $urandom();
    return {h, r[31:16], r[3:0], cnt, src, r[15:8], typ, chan, len, r[27:16]};
  endfunction

  task automatic push(input bit v, input logic [127:0] d, input bit f, input bit r);
    q_vld.push_back(v);
    q_dat.push_back(d);
    q_full.push_back(f);
    q_rst.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) push(1'b0, rand128(), 1'b0, 1'b0);
  endtask

  // gap < 0 picks a random gap per beat, occasionally long enough to hit the timeout.
  task automatic frame(input logic [31:0] h, input int len, input logic [15:0] cnt,
                       input logic [7:0] src, input logic [7:0] typ, input logic [7:0] chan,
                       input int beats, input int gap, input int fidx, input int fpct);
    int g;
    push(1'b1, mk_hdr(h, 16'(len), cnt, src, typ, chan), 1'b0, 1'b0);
    for (int b = 0; b < beats; b++) begin
      if (gap >= 0) g = gap;
      else if ($urandom_range(0, 99) < 5) g = int'($urandom_range(7, 9));
      else g = int'($urandom_range(0, 2));
      idle(g);
      push(1'b1, rand128(), (b == fidx) || (int'($urandom_range(0, 99)) < fpct), 1'b0);
    end
  endtask

  // Reference: walk the stimulus frame by frame and mark where each output event must appear.
  task automatic build_expect();
    int n, i, nb, got, gap;
    bit ferr;
    logic [127:0] beat;
`ifdef DS_FRAME_CNT_CHECK_EN
    bit first;
    logic [15:0] prev;
    first = 1'b1;
    prev  = '0;
`endif
    n = q_vld.size();
    e_wr = new[n]; e_done = new[n]; e_ferr = new[n]; e_eh = new[n]; e_to = new[n];
    e_ov = new[n]; e_seq = new[n]; fld_set = new[n]; e_din = new[n]; fld_val = new[n];
    e_fld = new[n]; e_total = new[n];
    i = 0;
    while (i < n) begin
      if (q_rst[i]) begin
`ifdef DS_FRAME_CNT_CHECK_EN
        first = 1'b1;
`endif
        i++;
        continue;
      end
      if (!q_vld[i]) begin
        i++;
        continue;
      end
      beat = q_dat[i];
      if (beat[127:96] != HDR) begin
        e_eh[i] = 1'b1;
        i++;
        continue;
      end
      fld_set[i] = 1'b1;
      fld_val[i] = {beat[75:60], beat[59:52], beat[43:36], beat[35:28]};
      nb   = (int'(beat[27:12]) + 15) / 16;
      ferr = 1'b0;
`ifdef DS_FRAME_CNT_CHECK_EN
      if (!first && beat[75:60] != 16'(prev + 16'd1)) begin
        e_seq[i] = 1'b1;
        ferr = 1'b1;
      end
      first = 1'b0;
      prev  = beat[75:60];
`endif
      if (nb == 0) begin
        e_done[i] = 1'b1;
        e_ferr[i] = ferr;
        i++;
        continue;
      end
      i++;
      got = 0;
      gap = 0;
      while (got < nb && i < n && !q_rst[i]) begin
        if (q_vld[i]) begin
          if (q_full[i]) begin
            e_ov[i] = 1'b1;
            ferr = 1'b1;
          end else begin
            e_wr[i]  = 1'b1;
            e_din[i] = q_dat[i];
          end
          got++;
          gap = 0;
          if (got == nb) begin
            e_done[i] = 1'b1;
            e_ferr[i] = ferr;
          end
          i++;
        end else begin
          gap++;
          if (gap == TMO) begin
            e_to[i] = 1'b1;
            i++;
            if (i < n && !q_rst[i]) i++;  // the drain slot swallows whatever arrives
            break;
          end
          i++;
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      if (q_rst[k]) e_fld[k] = '0;
      else if (fld_set[k]) e_fld[k] = fld_val[k];
      else e_fld[k] = (k == 0) ? 40'd0 : e_fld[k-1];
      if (q_rst[k] || k == 0) e_total[k] = '0;
      else e_total[k] = e_total[k-1] + 16'((e_done[k-1] && !e_ferr[k-1]) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (3) push(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    frame(HDR, 16, 16'd5, 8'h12, 8'h34, 8'h56, 1, 0, -1, 0);
    idle(2);
    frame(HDR, 40, 16'd6, 8'hA1, 8'hB2, 8'hC3, 3, 5, -1, 0);
    idle(2);
    push(1'b1, mk_hdr(32'h1234_5678, 16'd16, 16'd7, 8'h01, 8'h02, 8'h03), 1'b0, 1'b0);
    frame(HDR, 0, 16'd7, 8'h11, 8'h22, 8'h33, 0, 0, -1, 0);
    idle(2);
    frame(HDR, 48, 16'd8, 8'h44, 8'h55, 8'h66, 3, 1, 1, 0);
    idle(2);
    frame(HDR, 32, 16'd9, 8'h77, 8'h88, 8'h99, 1, 0, -1, 0);
    idle(12);
    frame(HDR, 1, 16'd10, 8'h0A, 8'h0B, 8'h0C, 1, 0, -1, 0);
    idle(1);
    frame(HDR, 32, 16'd11, 8'h1A, 8'h1B, 8'h1C, 1, 0, -1, 0);
    idle(8);
    push(1'b1, rand128(), 1'b0, 1'b0);
    idle(2);
    frame(HDR, 32, 16'd12, 8'h2A, 8'h2B, 8'h2C, 2, 7, -1, 0);
    idle(2);
    frame(HDR, 16, 16'd7, 8'h3A, 8'h3B, 8'h3C, 1, 0, -1, 0);
    frame(HDR, 16, 16'd9, 8'h4A, 8'h4B, 8'h4C, 1, 0, -1, 0);
    frame(HDR, 16, 16'hFFFF, 8'h5A, 8'h5B, 8'h5C, 1, 0, -1, 0);
    frame(HDR, 16, 16'd0, 8'h6A, 8'h6B, 8'h6C, 1, 0, -1, 0);
    idle(1);
    push(1'b1, mk_hdr(HDR, 16'd48, 16'd1, 8'h7A, 8'h7B, 8'h7C), 1'b0, 1'b0);
    push(1'b1, rand128(), 1'b0, 1'b0);
    push(1'b0, rand128(), 1'b0, 1'b1);
    frame(HDR, 16, 16'd100, 8'h8A, 8'h8B, 8'h8C, 1, 0, -1, 0);
    idle(2);
    seq_cnt = 16'd101;
    for (int f = 0; f < 150; f++) begin
      int len, nb, beats, r;
      logic [31:0] h;
      h = ($urandom_range(0, 9) == 0) ? $urandom() : HDR;
      r = int'($urandom_range(0, 9));
      if (r == 0) len = 0;
      else if (r == 1) len = 16;
      else if (r == 2) len = int'($urandom_range(1, 15));
      else len = int'($urandom_range(17, 80));
      nb = (len + 15) / 16;
      beats = (nb > 0 && $urandom_range(0, 9) == 0) ? nb - 1 : nb;
      if ($urandom_range(0, 9) == 0) seq_cnt = 16'(seq_cnt + 16'd2);
      frame(h, len, seq_cnt, 8'($urandom()), 8'($urandom()), 8'($urandom()), beats, -1, -1, 10);
      seq_cnt = 16'(seq_cnt + 16'd1);
      idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) push(1'b1, rand128(), 1'b0, 1'b0);
    end
    idle(4);

    build_expect();

    for (int k = 0; k < q_vld.size(); k++) begin
      rst_i  = q_rst[k];
      vld_i  = q_vld[k];
      flow_i = q_dat[k];
      full_i = q_full[k];
      @(posedge sys_clk_i);
      #1;
      cyc = k;
      check("wr_en", wr_en_o, e_wr[k]);
      if (e_wr[k]) check("din", din_o, e_din[k]);
      check("done", done_o, e_done[k]);
      check("frame_err", ferr_o, e_ferr[k]);
      check("err_header", eh_o, e_eh[k]);
      check("err_timeout", eto_o, e_to[k]);
      check("err_overflow", eov_o, e_ov[k]);
      check("err_seq", eseq_o, e_seq[k]);
      check("fields", {fcnt_o, src_o, type_o, chan_o}, e_fld[k]);
      check("rx_total", total_o, e_total[k]);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ds_timming_flow_parser.md
DS_TIMMING_FLOW_PARSER -- requirements
Module: ds_timming_flow_parser

Interface
REQ-001 Parameter HEADER_WORD, default 32'hFDF7_EB90, frame header value SHALL be compared against beat-0 [127:96].
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, idle-gap limit inside a frame SHALL be in cycles, range 2..65535.
REQ-003 sys_clk_i  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 us_timming_flow_vld_i  input  1  flow beat valid; there is no backpressure.
REQ-006 us_timming_flow_i  input  128  flow beat data.
REQ-007 ds_timming_wr_en_o  output  1  payload FIFO write strobe.
REQ-008 ds_timming_din_o  output  128  payload FIFO write data.
REQ-009 ds_timming_full_i  input  1  payload FIFO full.
REQ-010 frame_done_pluse_o  output  1  one-cycle pulse at frame end.
REQ-011 frame_err_o  output  1  valid with done pulse: 1 = frame had overflow or sequence error.
REQ-012 src_id_o / data_type_o / data_channel_o  output  8 each  fields latched from the current header.
REQ-013 frame_cnt_o  output  16  frame counter latched from the current header.
REQ-014 err_header_pluse_o / err_timeout_pluse_o / err_overflow_pluse_o / err_seq_pluse_o  output  1 each  error pulses.
REQ-015 rx_frame_total_o  output  16  count of done pulses with frame_err_o=0, wraps at 16'hFFFF->0.

Function
REQ-016 Beat-0 layout SHALL be: [127:96] header, [95:80] frame_len (ignored), [79:76] frame_type (ignored), [75:60] frame_cnt, [59:52] src_id, [51:44] des_id (ignored), [43:36] data_type, [35:28] data_channel, [27:12] data_field_len in bytes, [11:0] reserved.
REQ-017 Payload beat count N SHALL be ceil(data_field_len/16), computed in 13 bits; data_field_len=16 gives N=1, and data_field_len=0 gives N=0.
REQ-018 The FSM SHALL have three states: S_IDLE, S_PAYLOAD, S_DRAIN.
REQ-019 S_IDLE, vld with header match: latch fields and N, set beat counter 0; if N=0, pulse frame_done next cycle and stay in S_IDLE; else go to S_PAYLOAD.
REQ-020 S_IDLE, vld with header mismatch: drop the beat, pulse err_header_pluse_o once per beat, stay in S_IDLE.
REQ-021 S_PAYLOAD, each vld beat: register to ds_timming_din_o with ds_timming_wr_en_o=1 one cycle later if ds_timming_full_i=0 that cycle.
REQ-022 If full=1 on a payload beat, the beat SHALL be dropped with no write, err_overflow_pluse_o pulsed, and the frame error flag set.
REQ-023 On beat N, frame_done_pluse_o SHALL assert in the same cycle as the last write strobe (or the drop slot), with frame_err_o; the FSM SHALL then go to S_IDLE.
REQ-024 Headers SHALL NOT be detected inside S_PAYLOAD; every vld beat there is payload.
REQ-025 An idle gap counter SHALL count consecutive non-vld cycles in S_PAYLOAD; on reaching TIMEOUT_CYCLES it SHALL pulse err_timeout_pluse_o, emit no done pulse, and go to S_DRAIN.
REQ-026 S_DRAIN SHALL return to S_IDLE after one cycle; a vld beat during S_DRAIN SHALL be dropped without an error pulse.
REQ-027 Writes already issued before a timeout SHALL NOT be retracted.
REQ-028 rx_frame_total_o SHALL increment in the cycle after a clean done pulse.
REQ-029 When vld arrives in the same cycle that timeout is reached, the beat SHALL be accepted and the timeout cancelled.

Reset
REQ-030 On rst_i=1, state SHALL be S_IDLE, and all outputs and counters SHALL be 0 on the next edge.
REQ-031 A reset mid-frame SHALL abandon the frame with no done or error pulse; the next beat SHALL be treated as a header candidate.

Configuration
REQ-032 Macro DS_FRAME_CNT_CHECK_EN, when defined, SHALL compare each header frame_cnt with the previous good header's frame_cnt + 1 (16-bit wrap, first header after reset always accepted).
REQ-033 On a sequence mismatch it SHALL pulse err_seq_pluse_o in the cycle after the header and set the frame error flag, and the frame SHALL still be parsed.
REQ-034 When the macro is undefined, there SHALL be no comparison logic and err_seq_pluse_o SHALL be tied to 0.

Verification
REQ-035 Header FDF7EB90, len=16, cnt=5, src=8'h12, type=8'h34, chan=8'h56, then 1 payload beat -> one write, done=1, err=0, fields latched, total=1.
REQ-036 Header len=40 plus 3 payload beats with gaps of 5 cycles -> 3 writes in order, done aligned with the 3rd write.
REQ-037 Header 32'h1234_5678 -> err_header pulse, no write, state S_IDLE; a following valid frame is parsed normally.
REQ-038 full=1 during payload beat 2 of 3 -> 2 writes, err_overflow pulse, done with err=1, total unchanged.
REQ-039 With TIMEOUT_CYCLES=8, header len=32 and 1 payload beat, then silence -> err_timeout after 8 idle cycles, no done pulse; the next header is accepted.
REQ-040 With DS_FRAME_CNT_CHECK_EN defined, frame cnt 7 then 9 -> err_seq pulse on the second frame, done err=1; cnt 16'hFFFF then 0 -> no error.
